// File: rtl/acc_req_arbiter.sv
// acc_req_arbiter: round-robin sharing of one accelerator port with per-tid response routing
module acc_req_arbiter #(
  parameter int NR_REQ    = 2,
  parameter int DATA_W    = 128,
  parameter int RESP_W    = 64,
  parameter int TID_W     = 3,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NR_REQ-1:0]        req_valid_i,
  output logic [NR_REQ-1:0]        req_ready_o,
  input  logic [NR_REQ*DATA_W-1:0] req_data_i,
  input  logic [NR_REQ*TID_W-1:0]  req_tid_i,
  output logic                     acc_req_valid_o,
  input  logic                     acc_req_ready_i,
  output logic [DATA_W-1:0]        acc_req_data_o,
  output logic [TID_W-1:0]         acc_req_tid_o,
  input  logic                     acc_resp_valid_i,
  output logic                     acc_resp_ready_o,
  input  logic [TID_W-1:0]         acc_resp_tid_i,
  input  logic [RESP_W-1:0]        acc_resp_data_i,
  output logic [NR_REQ-1:0]        resp_valid_o,
  input  logic [NR_REQ-1:0]        resp_ready_i,
  output logic [RESP_W-1:0]        resp_data_o,
  output logic [TID_W-1:0]         resp_tid_o,
  output logic                     err_spurious_o
);
  localparam int NT = 2 ** TID_W;
  localparam int IW = NR_REQ > 1 ? $clog2(NR_REQ) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] MAXO = OW'(MAX_OUTST);

  logic [IW-1:0]     rr_ptr_q, lock_idx_q, grant, dst, idx;
  logic              lock_q, err_q, found, issue, hit, resp_fire;
  logic [NT-1:0]     busy_q;
  logic [IW-1:0]     src_q [NT];
  logic [OW-1:0]     outst_q [NR_REQ];
  logic [NR_REQ-1:0] elig;

  // Descending search so the candidate closest to rr_ptr_q is assigned last and wins
  always_comb begin
    elig  = '0;
    idx   = '0;
    found = 1'b0;
    grant = rr_ptr_q;
    for (int i = 0; i < NR_REQ; i++)
      elig[i] = req_valid_i[i] & (outst_q[i] < MAXO) & ~busy_q[req_tid_i[i*TID_W +: TID_W]];
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      idx = IW'((int'(rr_ptr_q) + k) % NR_REQ);
      if (elig[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
    if (lock_q) grant = lock_idx_q;
  end

  assign acc_req_valid_o  = lock_q ? req_valid_i[lock_idx_q] : found;
  assign acc_req_data_o   = req_data_i[int'(grant)*DATA_W +: DATA_W];
  assign acc_req_tid_o    = req_tid_i[int'(grant)*TID_W +: TID_W];
  assign issue            = acc_req_valid_o & acc_req_ready_i;
  assign req_ready_o      = NR_REQ'(issue) << grant;
  assign hit              = busy_q[acc_resp_tid_i];
  assign dst              = src_q[acc_resp_tid_i];
  assign resp_valid_o     = NR_REQ'(acc_resp_valid_i & hit) << dst;
  assign acc_resp_ready_o = hit ? resp_ready_i[dst] : 1'b1;
  assign resp_fire        = acc_resp_valid_i & hit & resp_ready_i[dst];
  assign resp_data_o      = acc_resp_data_i;
  assign resp_tid_o       = acc_resp_tid_i;
  assign err_spurious_o   = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      for (int t = 0; t < NT; t++) src_q[t] <= '0;
      for (int i = 0; i < NR_REQ; i++) outst_q[i] <= '0;
    end else begin
      lock_q     <= acc_req_valid_o & ~acc_req_ready_i;
      lock_idx_q <= grant;
      err_q      <= acc_resp_valid_i & ~hit;
      if (resp_fire) begin
        assert (outst_q[dst] != '0);
        busy_q[acc_resp_tid_i] <= 1'b0;
      end
      if (issue) begin
        busy_q[acc_req_tid_o] <= 1'b1;
        src_q[acc_req_tid_o]  <= grant;
        rr_ptr_q              <= (int'(grant) == NR_REQ - 1) ? '0 : grant + IW'(1);
      end
      for (int i = 0; i < NR_REQ; i++) begin
        if (issue && grant == IW'(i) && !(resp_fire && dst == IW'(i)))
          outst_q[i] <= outst_q[i] + OW'(1);
        else if (resp_fire && dst == IW'(i) && !(issue && grant == IW'(i)))
          outst_q[i] <= outst_q[i] - OW'(1);
      end
    end
  end
endmodule

// File: tb/tb_acc_req_arbiter.sv
// tb_acc_req_arbiter: directed scoreboard bench for acc_req_arbiter
module tb_acc_req_arbiter;
  localparam int N = 2, DW = 128, RW = 64, TW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tid;
  logic            acc_req_valid, acc_req_ready, acc_resp_valid, acc_resp_ready, err;
  logic [DW-1:0]   acc_req_data;
  logic [TW-1:0]   acc_req_tid, acc_resp_tid, resp_tid;
  logic [RW-1:0]   acc_resp_data, resp_data;

  int total = 0, bad = 0;

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  acc_req_arbiter #(.NR_REQ(N), .DATA_W(DW), .RESP_W(RW), .TID_W(TW), .MAX_OUTST(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data), .req_tid_i(req_tid),
    .acc_req_valid_o(acc_req_valid), .acc_req_ready_i(acc_req_ready),
    .acc_req_data_o(acc_req_data), .acc_req_tid_o(acc_req_tid),
    .acc_resp_valid_i(acc_resp_valid), .acc_resp_ready_o(acc_resp_ready),
    .acc_resp_tid_i(acc_resp_tid), .acc_resp_data_i(acc_resp_data),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_data_o(resp_data), .resp_tid_o(resp_tid), .err_spurious_o(err)
  );

  function automatic logic [DW-1:0] mkd(int r, int t);
    return {56'hABCD, 8'(r), 56'h1234, 8'(t)};
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(int r, logic v, int t);
    req_valid[r]          = v;
    req_tid[r*TW +: TW]   = TW'(t);
    req_data[r*DW +: DW]  = mkd(r, t);
  endtask

  task automatic push(int g, int t);
    exp_t e;
    e.rdy  = N'(1) << g;
    e.tid  = TW'(t);
    e.data = mkd(g, t);
    exp_q.push_back(e);
  endtask

  task automatic resp(logic v, int t);
    acc_resp_valid = v;
    acc_resp_tid   = TW'(t);
    acc_resp_data  = 64'hF00D_0000_0000_0000 | 64'(t);
  endtask

  // Any issue handshake seen before the edge must match the oldest expected grant
  task automatic cyc();
    exp_t e;
    if (acc_req_valid && acc_req_ready) begin
      chk("sb_has_entry", DW'(exp_q.size() > 0), DW'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("iss_rdy", DW'(req_ready), DW'(e.rdy));
        chk("iss_tid", DW'(acc_req_tid), DW'(e.tid));
        chk("iss_data", acc_req_data, e.data);
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    acc_req_ready = 1'b0;
    resp(1'b0, 0);
    resp_ready = '1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    req_valid = '0; req_data = '0; req_tid = '0;
    acc_req_ready = 1'b0; resp_ready = '1;
    resp(1'b0, 0);
    @(negedge clk);
    #2;
    chk("rst_acc_valid", DW'(acc_req_valid), DW'(0));
    chk("rst_req_ready", DW'(req_ready), DW'(0));
    chk("rst_resp_valid", DW'(resp_valid), DW'(0));
    chk("rst_err", DW'(err), DW'(0));
    chk("rst_resp_ready", DW'(acc_resp_ready), DW'(1));
    rst = 1'b0;
    @(negedge clk);

    // round-robin alternation with both requesters always valid
    acc_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(0, 1'b1, (k + 1) / 2);
      set_req(1, 1'b1, 4 + k / 2);
      push(k % 2, (k % 2 == 1) ? 4 + k / 2 : (k + 1) / 2);
      #2;
      chk("t1_valid", DW'(acc_req_valid), DW'(1));
      cyc();
    end
    set_req(0, 1'b0, 0); set_req(1, 1'b0, 0);
    do_reset();

    // stall locks grant on req0 even once rr_ptr points at req1
    acc_req_ready = 1'b1;
    set_req(0, 1'b1, 0); push(0, 0); #2; cyc();
    acc_req_ready = 1'b0;
    set_req(0, 1'b1, 1); #2;
    chk("t2_stall_v", DW'(acc_req_valid), DW'(1));
    chk("t2_stall_rdy", DW'(req_ready), DW'(0));
    chk("t2_stall_data", acc_req_data, mkd(0, 1));
    cyc();
    set_req(1, 1'b1, 2);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("t2_lock_data", acc_req_data, mkd(0, 1));
      chk("t2_lock_rdy", DW'(req_ready), DW'(0));
      cyc();
    end
    acc_req_ready = 1'b1;
    push(0, 1); #2; cyc();
    set_req(0, 1'b0, 0); push(1, 2); #2; cyc();
    set_req(1, 1'b0, 0);
    do_reset();

    // outstanding limit and release by response
    acc_req_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      set_req(0, 1'b1, t); push(0, t); #2; cyc();
    end
    set_req(0, 1'b1, 4); #2;
    chk("t3_full_rdy", DW'(req_ready), DW'(0));
    chk("t3_full_v", DW'(acc_req_valid), DW'(0));
    cyc();
    resp(1'b1, 2); #2;
    chk("t3_resp_v", DW'(resp_valid), DW'(2'b01));
    chk("t3_resp_rdy", DW'(acc_resp_ready), DW'(1));
    chk("t3_resp_data", DW'(resp_data), DW'(64'hF00D_0000_0000_0002));
    chk("t3_resp_tid", DW'(resp_tid), DW'(2));
    chk("t3_still_full", DW'(acc_req_valid), DW'(0));
    cyc();
    resp(1'b0, 0); push(0, 4); #2; cyc();
    set_req(0, 1'b0, 0);
    do_reset();

    // out-of-order responses, freed tid blocked in its release cycle
    acc_req_ready = 1'b1;
    set_req(0, 1'b1, 5); push(0, 5); #2; cyc();
    set_req(0, 1'b0, 0); set_req(1, 1'b1, 6); push(1, 6); #2; cyc();
    set_req(1, 1'b0, 0); resp(1'b1, 6); #2;
    chk("t4_resp6_v", DW'(resp_valid), DW'(2'b10));
    chk("t4_resp6_tid", DW'(resp_tid), DW'(6));
    chk("t4_resp6_rdy", DW'(acc_resp_ready), DW'(1));
    cyc();
    resp(1'b1, 5); set_req(1, 1'b1, 5); #2;
    chk("t4_resp5_v", DW'(resp_valid), DW'(2'b01));
    chk("t4_blocked", DW'(acc_req_valid), DW'(0));
    cyc();
    resp(1'b0, 0); push(1, 5); #2; cyc();
    set_req(1, 1'b0, 0); set_req(0, 1'b1, 6); push(0, 6); #2; cyc();
    set_req(0, 1'b0, 0);
    do_reset();

    // spurious response dropped with a one-cycle error pulse
    resp(1'b1, 7); #2;
    chk("t5_drop_rdy", DW'(acc_resp_ready), DW'(1));
    chk("t5_drop_v", DW'(resp_valid), DW'(0));
    chk("t5_err_early", DW'(err), DW'(0));
    cyc();
    resp(1'b0, 0); #2;
    chk("t5_err_pulse", DW'(err), DW'(1));
    cyc();
    #2;
    chk("t5_err_clear", DW'(err), DW'(0));
    cyc();

    // response backpressure, then async reset in the middle of the stall
    acc_req_ready = 1'b1;
    set_req(1, 1'b1, 3); push(1, 3); #2; cyc();
    set_req(1, 1'b0, 0); resp(1'b1, 3); resp_ready = 2'b01; set_req(0, 1'b1, 3);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk("t6_resp_v", DW'(resp_valid), DW'(2'b10));
      chk("t6_resp_rdy", DW'(acc_resp_ready), DW'(0));
      chk("t6_busy_held", DW'(acc_req_valid), DW'(0));
      cyc();
    end
    set_req(0, 1'b0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_resp_v", DW'(resp_valid), DW'(0));
    chk("t6_rst_resp_rdy", DW'(acc_resp_ready), DW'(1));
    chk("t6_rst_acc_v", DW'(acc_req_valid), DW'(0));
    chk("t6_rst_err", DW'(err), DW'(0));
    @(negedge clk);
    resp(1'b0, 0); resp_ready = '1;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      set_req(1, 1'b1, t); push(1, t); #2; cyc();
    end
    set_req(1, 1'b1, 4); #2;
    chk("t6_cnt_full", DW'(acc_req_valid), DW'(0));
    cyc();
    set_req(1, 1'b0, 0);

    chk("sb_drained", DW'(exp_q.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
